// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round sequencer slice.
//   seq_state_t  : sequencer state encoding (IDLE, LOAD, ROUND, FINAL, HOLD).
//   NR_AES*      : round counts for AES-128/192/256.
//   nr_is_legal  : true when a round count matches one of the key sizes.
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        HOLD  = 3'd4
    } seq_state_t;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    function automatic bit nr_is_legal(input int nr);
        return (nr == NR_AES128) || (nr == NR_AES192) || (nr == NR_AES256);
    endfunction

endpackage

// File: rtl/round_timer.sv
// ----------------------------------------------------------------------------
// round_timer
// Modulo-ROUND_LAT cycle counter that times one AES round.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count enable
//   tc_o   : terminal count, high while the count equals ROUND_LAT-1
// ----------------------------------------------------------------------------
module round_timer #(
    parameter int ROUND_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [3:0] LAST = 4'(ROUND_LAT - 1);

    logic [3:0] cnt_q;

    // With ROUND_LAT = 1 the count never leaves 0, so tc_o is constantly 1.
    assign tc_o = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            cnt_q <= tc_o ? 4'd0 : cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// ----------------------------------------------------------------------------
// aes_round_sequencer
// Control sequencer for AES-128/192/256 encryption. Walks round 0 (initial
// AddRoundKey), rounds 1..NR-1 (with MixColumns) and round NR (without),
// spending ROUND_LAT cycles in each, then holds the ciphertext until the
// consumer takes it.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   start       : new block request, honoured only in IDLE or HOLD
//   out_ready   : consumer accepts the ciphertext while done is high
//   busy        : high in LOAD, ROUND and FINAL
//   load_sel    : datapath mux, 0 = plaintext, 1 = round register
//   mix_en      : MixColumns enable, high only in ROUND
//   state_en    : round-register enable, pulses at the end of each round
//   key_en      : key-expansion advance, same timing as state_en
//   round_count : current round index 0..NR
//   ct_en       : ciphertext register load, pulses at the end of FINAL
//   done        : ciphertext valid, high throughout HOLD
// ----------------------------------------------------------------------------
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out_ready,
    output logic       busy,
    output logic       load_sel,
    output logic       mix_en,
    output logic       state_en,
    output logic       key_en,
    output logic [3:0] round_count,
    output logic       ct_en,
    output logic       done
);

    if (!nr_is_legal(NR)) begin : g_bad_nr
        $error("aes_round_sequencer: NR must be 10, 12 or 14");
    end
    if (ROUND_LAT < 1 || ROUND_LAT > 15) begin : g_bad_lat
        $error("aes_round_sequencer: ROUND_LAT must be in 1..15");
    end

    localparam logic [3:0] LAST_FULL = 4'(NR - 1);

    seq_state_t state_q;
    logic [3:0] round_q;
    logic       tc;
    logic       in_round;

    assign in_round = (state_q == LOAD) || (state_q == ROUND) || (state_q == FINAL);

    // Every exit from a busy state happens on tc, where the timer wraps to 0
    // by itself; clearing it outside the busy states makes each state start
    // from a zero count.
    round_timer #(
        .ROUND_LAT (ROUND_LAT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!in_round),
        .en_i  (in_round),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            round_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        round_q <= '0;
                    end
                end
                LOAD: begin
                    if (tc) begin
                        state_q <= ROUND;
                        round_q <= 4'd1;
                    end
                end
                ROUND: begin
                    if (tc) begin
                        round_q <= round_q + 4'd1;
                        // Leaving the last full round: the next one skips MixColumns.
                        if (round_q == LAST_FULL) begin
                            state_q <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    if (tc) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // start is only honoured together with out_ready, which
                    // gives the back-to-back path straight into LOAD.
                    if (out_ready) begin
                        state_q <= start ? LOAD : IDLE;
                        round_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    round_q <= '0;
                end
            endcase
        end
    end

    // Moore decode from registered state only, so reset clears the outputs
    // without waiting for a clock edge.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        busy        = 1'b0;
        load_sel    = 1'b0;
        mix_en      = 1'b0;
        state_en    = 1'b0;
        key_en      = 1'b0;
        ct_en       = 1'b0;
        done        = 1'b0;
        round_count = round_q;
        case (state_q)
            LOAD: begin
                busy     = 1'b1;
                state_en = tc;
                key_en   = tc;
            end
            ROUND: begin
                busy     = 1'b1;
                load_sel = 1'b1;
                mix_en   = 1'b1;
                state_en = tc;
                key_en   = tc;
            end
            FINAL: begin
                busy     = 1'b1;
                load_sel = 1'b1;
                state_en = tc;
                key_en   = tc;
                ct_en    = tc;
            end
            HOLD: begin
                done = 1'b1;
            end
            default: begin
                round_count = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ----------------------------------------------------------------------------
// tb_aes_round_sequencer
// Three sequencer instances: A (NR=10, LAT=2), B (NR=14, LAT=3) and
// C (NR=12, LAT=1). Expected per-cycle output vectors are pushed to a queue
// per instance when stimulus is driven and popped one per clock, 1 time unit
// after the rising edge. Vector layout:
//   {busy, load_sel, mix_en, state_en, key_en, ct_en, done, round_count[3:0]}
// k = 1 is the first cycle after the edge that accepted start.
// ----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    logic clk;
    logic rst;
    logic start_a, start_b, start_c;
    logic out_ready_a, out_ready_b, out_ready_c;

    logic       busy_a, load_sel_a, mix_en_a, state_en_a, key_en_a, ct_en_a, done_a;
    logic       busy_b, load_sel_b, mix_en_b, state_en_b, key_en_b, ct_en_b, done_b;
    logic       busy_c, load_sel_c, mix_en_c, state_en_c, key_en_c, ct_en_c, done_c;
    logic [3:0] rc_a, rc_b, rc_c;
    logic [10:0] act_a, act_b, act_c;

    logic [10:0] q_a[$];
    logic [10:0] q_b[$];
    logic [10:0] q_c[$];

    int n_cmp;
    int n_mism;
    int cyc;
    int n_se_a, n_ct_a, n_done_rise_a;
    int n_se_b, n_done_b;
    int n_done_c, n_load0_c, n_ct_c;
    logic done_prev_a;

    assign act_a = {busy_a, load_sel_a, mix_en_a, state_en_a, key_en_a, ct_en_a, done_a, rc_a};
    assign act_b = {busy_b, load_sel_b, mix_en_b, state_en_b, key_en_b, ct_en_b, done_b, rc_b};
    assign act_c = {busy_c, load_sel_c, mix_en_c, state_en_c, key_en_c, ct_en_c, done_c, rc_c};

    aes_round_sequencer #(.NR(10), .ROUND_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .out_ready(out_ready_a),
        .busy(busy_a), .load_sel(load_sel_a), .mix_en(mix_en_a), .state_en(state_en_a),
        .key_en(key_en_a), .round_count(rc_a), .ct_en(ct_en_a), .done(done_a)
    );

    aes_round_sequencer #(.NR(14), .ROUND_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .out_ready(out_ready_b),
        .busy(busy_b), .load_sel(load_sel_b), .mix_en(mix_en_b), .state_en(state_en_b),
        .key_en(key_en_b), .round_count(rc_b), .ct_en(ct_en_b), .done(done_b)
    );

    aes_round_sequencer #(.NR(12), .ROUND_LAT(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .out_ready(out_ready_c),
        .busy(busy_c), .load_sel(load_sel_c), .mix_en(mix_en_c), .state_en(state_en_c),
        .key_en(key_en_c), .round_count(rc_c), .ct_en(ct_en_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs k cycles after start was accepted, from the round
    // schedule: round r occupies cycles r*rl+1 .. (r+1)*rl, HOLD follows.
    function automatic logic [10:0] exp_vec(input int nr, input int rl, input int k);
        int   len;
        int   r;
        int   pos;
        logic tc;
        logic [10:0] v;
        len = (nr + 1) * rl;
        v   = '0;
        if (k >= 1 && k <= len) begin
            r   = (k - 1) / rl;
            pos = (k - 1) % rl;
            tc  = (pos == rl - 1);
            v   = {1'b1, (r != 0), (r >= 1 && r < nr), tc, tc, (tc && r == nr), 1'b0, 4'(r)};
        end else if (k == len + 1) begin
            v = {7'b0000001, 4'(nr)};
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input int nr, input int rl, input int k1, input int k2);
        for (int k = k1; k <= k2; k++) begin
            case (id)
                0:       q_a.push_back(exp_vec(nr, rl, k));
                1:       q_b.push_back(exp_vec(nr, rl, k));
                default: q_c.push_back(exp_vec(nr, rl, k));
            endcase
        end
    endtask

    task automatic push_zero(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            case (id)
                0:       q_a.push_back('0);
                1:       q_b.push_back('0);
                default: q_c.push_back('0);
            endcase
        end
    endtask

    task automatic clr_counts();
        n_se_a = 0; n_ct_a = 0; n_done_rise_a = 0;
        n_se_b = 0; n_done_b = 0;
        n_done_c = 0; n_load0_c = 0; n_ct_c = 0;
    endtask

    // One clock: advance, then compare every instance with pending expectations.
    task automatic tick();
        logic [10:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check($sformatf("A.vec@%0d", cyc), 32'(act_a), 32'(e));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check($sformatf("B.vec@%0d", cyc), 32'(act_b), 32'(e));
        end
        if (q_c.size() > 0) begin
            e = q_c.pop_front();
            check($sformatf("C.vec@%0d", cyc), 32'(act_c), 32'(e));
        end
        n_se_a        += int'(state_en_a);
        n_ct_a        += int'(ct_en_a);
        n_done_rise_a += int'(done_a && !done_prev_a);
        done_prev_a    = done_a;
        n_se_b        += int'(state_en_b);
        n_done_b      += int'(done_b);
        n_done_c      += int'(done_c);
        n_load0_c     += int'(busy_c && !load_sel_c);
        n_ct_c        += int'(ct_en_c);
    endtask

    initial begin
        n_cmp = 0; n_mism = 0; cyc = 0; done_prev_a = 1'b0;
        clr_counts();
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b0; out_ready_c = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset.A", 32'(act_a), 32'h0);
        check("reset.B", 32'(act_b), 32'h0);
        check("reset.C", 32'(act_c), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        push_zero(0, 2);
        repeat (2) tick();

        // Defaults, single start pulse, consumer always ready.
        clr_counts();
        push(0, 10, 2, 1, 23);
        push_zero(0, 2);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (24) tick();
        check("t1.state_en_pulses", 32'(n_se_a), 32'd11);
        check("t1.ct_en_pulses", 32'(n_ct_a), 32'd1);
        check("t1.done_rises", 32'(n_done_rise_a), 32'd1);

        // NR=14, LAT=3, consumer stalls 20 cycles, then one-cycle out_ready.
        clr_counts();
        push(1, 14, 3, 1, 46);
        for (int i = 0; i < 19; i++) push(1, 14, 3, 46, 46);
        push_zero(1, 2);
        start_b = 1'b1; tick(); start_b = 1'b0;
        repeat (45) tick();
        repeat (19) tick();
        out_ready_b = 1'b1; tick(); out_ready_b = 1'b0;
        tick();
        check("t2.state_en_pulses", 32'(n_se_b), 32'd15);
        check("t2.done_cycles", 32'(n_done_b), 32'd20);

        // NR=12, LAT=1, start and out_ready held: a block every 14 cycles.
        clr_counts();
        for (int i = 1; i <= 42; i++) push(2, 12, 1, ((i - 1) % 14) + 1, ((i - 1) % 14) + 1);
        push_zero(2, 2);
        start_c = 1'b1;
        repeat (42) tick();
        start_c = 1'b0;
        repeat (2) tick();
        check("t3.done_cycles", 32'(n_done_c), 32'd3);
        check("t3.load_sel0_cycles", 32'(n_load0_c), 32'd3);
        check("t3.ct_en_pulses", 32'(n_ct_c), 32'd3);

        // Asynchronous reset in round 5, then a full clean block.
        push(0, 10, 2, 1, 11);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (10) tick();
        check("t4.round_before_reset", 32'(rc_a), 32'd5);
        #2 rst = 1'b0;
        #1 check("t4.async_clear", 32'(act_a), 32'h0);
        clr_counts();
        push_zero(0, 2);
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b1;
        check("t4.aborted_ct_en", 32'(n_ct_a), 32'd0);
        check("t4.aborted_done", 32'(n_done_rise_a), 32'd0);
        clr_counts();
        push(0, 10, 2, 1, 23);
        push_zero(0, 2);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (24) tick();
        check("t4.state_en_pulses", 32'(n_se_a), 32'd11);

        // start pulsed again in round 3 is ignored.
        clr_counts();
        push(0, 10, 2, 1, 23);
        push_zero(0, 2);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (6) tick();
        check("t5.round_at_restart", 32'(rc_a), 32'd3);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (17) tick();
        check("t5.ct_en_pulses", 32'(n_ct_a), 32'd1);
        check("t5.done_rises", 32'(n_done_rise_a), 32'd1);
        check("t5.idle_after", 32'(busy_a), 32'd0);

        // HOLD stall with start high, then back-to-back restart into LOAD.
        clr_counts();
        out_ready_a = 1'b0;
        push(0, 10, 2, 1, 23);
        for (int i = 0; i < 4; i++) push(0, 10, 2, 23, 23);
        push(0, 10, 2, 1, 23);
        push_zero(0, 2);
        start_a = 1'b1; tick(); start_a = 1'b0;
        repeat (22) tick();
        start_a = 1'b1;
        repeat (4) tick();
        out_ready_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (22) tick();
        repeat (2) tick();
        check("t6.ct_en_pulses", 32'(n_ct_a), 32'd2);
        check("t6.done_rises", 32'(n_done_rise_a), 32'd2);

        check("queues_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
